// File: rtl/alu_pkg.sv
// Shared ALU opcodes and arbiter state encoding.
// Opcodes above ALU_OP_MAX are illegal and yield a zero result.
package alu_pkg;

    localparam int ALU_ADD    = 0;
    localparam int ALU_SUB    = 1;
    localparam int ALU_AND    = 2;
    localparam int ALU_OR     = 3;
    localparam int ALU_XOR    = 4;
    localparam int ALU_SLT    = 5;
    localparam int ALU_OP_MAX = 5;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: add/sub/and/or/xor/unsigned-slt.
// Zero latency, no flow control; illegal opcodes give result 0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  alu_control,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero
);

    always_comb begin
        alu_result = '0;
        case (alu_control)
            OP_W'(ALU_ADD): alu_result = a + b;
            OP_W'(ALU_SUB): alu_result = a - b;
            OP_W'(ALU_AND): alu_result = a & b;
            OP_W'(ALU_OR):  alu_result = a | b;
            OP_W'(ALU_XOR): alu_result = a ^ b;
            OP_W'(ALU_SLT): alu_result = WIDTH'(a < b);
            default:        alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared ALU with a registered response slot.
// Accept in cycle N gives rsp_valid in N+1; req_ready drops while the slot is held by ~rsp_ready.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    input  logic [2*OP_W-1:0]    req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_illegal
);

    arb_state_t         r_state;
    logic               r_last_grant;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_zero;
    logic               r_rsp_illegal;

    logic [1:0]         w_grant;
    logic               w_slot_free;
    logic               w_accept;
    logic               w_sel;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [OP_W-1:0]    w_op;
    logic [WIDTH-1:0]   w_alu_result;
    logic               w_alu_zero;

    // Grant depends only on valids and history, never on operand data.
    always_comb begin
        w_grant = 2'b00;
        case (req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_slot_free = (r_state == IDLE) | rsp_ready;
    assign req_ready   = (rst || !w_slot_free) ? 2'b00 : w_grant;
    assign w_accept    = |(req_valid & req_ready);
    assign w_sel       = req_ready[1];

    assign w_a  = w_sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
    assign w_b  = w_sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
    assign w_op = w_sel ? req_op[2*OP_W-1:OP_W]  : req_op[OP_W-1:0];

    alu #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) u_alu (
        .a           (w_a),
        .b           (w_b),
        .alu_control (w_op),
        .alu_result  (w_alu_result),
        .zero        (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= 1'b0;
            r_rsp_result  <= '0;
            r_rsp_zero    <= 1'b0;
            r_rsp_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready && !w_accept) begin
                        r_state     <= IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase
            if (w_accept) begin
                r_rsp_result  <= w_alu_result;
                r_rsp_zero    <= w_alu_zero;
                r_rsp_id      <= w_sel;
                r_rsp_illegal <= (w_op > OP_W'(ALU_OP_MAX));
                r_last_grant  <= w_sel;
            end
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
    assign rsp_zero    = r_rsp_zero;
    assign rsp_illegal = r_rsp_illegal;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, single, contention, backpressure, illegal op, reset mid-response.
module tb_alu_arbiter;

    localparam int WIDTH = 16;
    localparam int OP_W  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [WIDTH-1:0]    a0, a1, b0, b1;
    logic [OP_W-1:0]     op0, op1;
    logic [2*WIDTH-1:0]  req_a;
    logic [2*WIDTH-1:0]  req_b;
    logic [2*OP_W-1:0]   req_op;
    logic                rsp_valid;
    logic                rsp_ready;
    logic                rsp_id;
    logic [WIDTH-1:0]    rsp_result;
    logic                rsp_zero;
    logic                rsp_illegal;

    int n_assert = 0;
    int n_fail   = 0;

    assign req_a  = {a1, a0};
    assign req_b  = {b1, b0};
    assign req_op = {op1, op0};

    always #5 clk = ~clk;

    alu_arbiter #(
        .WIDTH (WIDTH),
        .OP_W  (OP_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then park on the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_rsp(input string tag, input logic v, input logic id,
                             input logic [WIDTH-1:0] res, input logic z, input logic ill);
        check({tag, "_valid"},   32'(rsp_valid),   32'(v));
        check({tag, "_id"},      32'(rsp_id),      32'(id));
        check({tag, "_result"},  32'(rsp_result),  32'(res));
        check({tag, "_zero"},    32'(rsp_zero),    32'(z));
        check({tag, "_illegal"}, 32'(rsp_illegal), 32'(ill));
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        a0 = 16'd5; b0 = 16'd3; op0 = 4'h1;
        a1 = 16'd2; b1 = 16'd7; op1 = 4'h5;

        // Reset held two cycles with both requesters valid
        @(negedge clk);
        step();
        step();
        #1;
        check("reset_req_ready", 32'(req_ready), 32'h0);
        check_rsp("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Contention: r0 computes 5-3=2, r1 computes 2<7=1; strict alternation starting at r0
        rst       = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("cont_req_ready_%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check($sformatf("cont_id_%0d", i), 32'(rsp_id), 32'(i % 2));
            check($sformatf("cont_result_%0d", i), 32'(rsp_result), (i % 2 == 0) ? 32'h2 : 32'h1);
            check($sformatf("cont_valid_%0d", i), 32'(rsp_valid), 32'h1);
        end
        req_valid = 2'b00;
        step();
        check("drain_valid", 32'(rsp_valid), 32'h0);

        // Single request from r1: 0xFFFF + 1 wraps to zero
        a1 = 16'hFFFF; b1 = 16'h0001; op1 = 4'h0;
        req_valid = 2'b10;
        #1;
        check("single_req_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b00;
        check_rsp("single", 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Backpressure: r0 AND, then hold rsp_ready low for 3 cycles with r1 waiting
        a0 = 16'h00F0; b0 = 16'h0FF0; op0 = 4'h2;
        req_valid = 2'b01;
        #1;
        check("bp_first_req_ready", 32'(req_ready), 32'h1);
        step();
        check_rsp("bp_first", 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        a1 = 16'h0003; b1 = 16'h0004; op1 = 4'h0;
        req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("bp_req_ready_%0d", i), 32'(req_ready), 32'h0);
            step();
            check_rsp($sformatf("bp_hold_%0d", i), 1'b1, 1'b0, 16'h00F0, 1'b0, 1'b0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = 2'b00;
        check_rsp("bp_next", 1'b1, 1'b1, 16'h0007, 1'b0, 1'b0);

        // Illegal opcode 0x9
        a0 = 16'h1234; b0 = 16'h5678; op0 = 4'h9;
        req_valid = 2'b01;
        #1;
        check("illegal_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        check_rsp("illegal", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Reset mid-response: r0 wins last, so only a restored last_grant lets r0 win again
        a0 = 16'h0003; b0 = 16'h0004; op0 = 4'h0;
        a1 = 16'h0009; b1 = 16'h0002; op1 = 4'h1;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        check_rsp("pre_rst", 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        check_rsp("mid_rst", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst       = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        check_rsp("post_rst", 1'b1, 1'b0, 16'h0007, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
